// File: rtl/freq_div_ctrl_pkg.sv
// Shared types and constants for the frequency-divider reconfiguration controller.
//   DIV_W   : width of a divisor word
//   state_e : controller FSM states
package freq_div_ctrl_pkg;
  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISABLE = 2'd1,
    LOAD    = 2'd2,
    RESUME  = 2'd3
  } state_e;
endpackage

// File: rtl/freq_div_ctrl_if.sv
// Bus between two divisor requesters / run control and the controller.
//   master : requester side (drives Valid/Div/RunEn, observes the rest)
//   slave  : controller side (drives Ready and the divider-facing outputs)
interface freq_div_ctrl_if;
  import freq_div_ctrl_pkg::*;

  logic             Req0Valid;
  logic [DIV_W-1:0] Req0Div;
  logic             Req0Ready;
  logic             Req1Valid;
  logic [DIV_W-1:0] Req1Div;
  logic             Req1Ready;
  logic             RunEn;
  logic [DIV_W-1:0] DivDin;
  logic             DivConfig;
  logic             DivEnable;
  logic [DIV_W-1:0] ActiveDiv;
  logic             Busy;
  logic             Err;

  modport master (
    output Req0Valid, Req0Div, Req1Valid, Req1Div, RunEn,
    input  Req0Ready, Req1Ready, DivDin, DivConfig, DivEnable, ActiveDiv, Busy, Err
  );

  modport slave (
    input  Req0Valid, Req0Div, Req1Valid, Req1Div, RunEn,
    output Req0Ready, Req1Ready, DivDin, DivConfig, DivEnable, ActiveDiv, Busy, Err
  );
endinterface

// File: rtl/freq_div_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
//   Clk, Reset : clock, async active-low reset
//   i_valid    : request valids {req1, req0}
//   i_en       : arbitration allowed this cycle
//   o_grant    : one-hot grant (combinational from i_valid)
// Any grant is a completed transfer, so the pointer moves to the loser side.
module rr_arb2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] i_valid,
  input  logic       i_en,
  output logic [1:0] o_grant
);
  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (&i_valid) o_grant = r_ptr ? 2'b10 : 2'b01;
      else          o_grant = i_valid;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)          r_ptr <= 1'b0;
    else if (o_grant[0]) r_ptr <= 1'b1;
    else if (o_grant[1]) r_ptr <= 1'b0;
  end
endmodule

// File: rtl/freq_div_ctrl.sv
// Frequency-divider reconfiguration controller.
//   Clk, Reset : clock, async active-low reset
//   bus        : requester handshake, RunEn, and divider-facing outputs
// A legal divisor takes the divider through disable (SETTLE_CYCLES), a single
// ConfigDiv pulse, one resume cycle, then back to idle. Illegal divisors are
// consumed with a one-cycle Err pulse and no side effects.
module freq_div_ctrl import freq_div_ctrl_pkg::*; #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DIV_MIN       = 2
) (
  input logic            Clk,
  input logic            Reset,
  freq_div_ctrl_if.slave bus
);
  logic [1:0]       w_grant;
  logic             w_xfer;
  logic [DIV_W-1:0] w_div;

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_din;
  logic [DIV_W-1:0] r_active;
  logic             r_cfg;
  logic             r_en;
  logic             r_busy;
  logic             r_err;
  logic             r_configured;

  rr_arb2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_valid ({bus.Req1Valid, bus.Req0Valid}),
    .i_en    (r_state == IDLE),
    .o_grant (w_grant)
  );

  assign w_xfer = |w_grant;
  assign w_div  = w_grant[1] ? bus.Req1Div : bus.Req0Div;

  assign bus.Req0Ready = w_grant[0];
  assign bus.Req1Ready = w_grant[1];
  assign bus.DivDin    = r_din;
  assign bus.DivConfig = r_cfg;
  assign bus.DivEnable = r_en;
  assign bus.ActiveDiv = r_active;
  assign bus.Busy      = r_busy;
  assign bus.Err       = r_err;

  // Outputs are registered against the state being entered, so they line up
  // with r_state cycle for cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_div        <= '0;
      r_din        <= '0;
      r_active     <= '0;
      r_cfg        <= 1'b0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_configured <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_cfg <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_en <= bus.RunEn && r_configured;
          if (w_xfer) begin
            if (w_div < DIV_W'(DIV_MIN)) begin
              r_err <= 1'b1;
            end else begin
              r_div   <= w_div;
              r_state <= DISABLE;
              r_cnt   <= 4'(SETTLE_CYCLES - 1);
              r_busy  <= 1'b1;
              r_en    <= 1'b0;
            end
          end
        end
        DISABLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= LOAD;
            r_cfg   <= 1'b1;
            r_din   <= r_div;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        LOAD: begin
          r_state      <= RESUME;
          r_active     <= r_div;
          r_configured <= 1'b1;
        end
        RESUME: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_en    <= bus.RunEn && r_configured;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
